// File: rtl/div_unit.sv
// div_unit -- iterative 32-bit integer divider for DIV (signed) / DIVU.
//
// Radix-2 restoring divider producing one quotient bit per clock. Operand
// magnitudes are taken at start, and signs are fixed up on the last
// iteration. The result is held until the execute stage drops start_i.
//
// Ports:
//   clk           core clock, rising edge
//   rst           asynchronous active-low reset
//   signed_div_i  1 = signed divide, 0 = unsigned (sampled at start)
//   opdata1_i     dividend (sampled at start)
//   opdata2_i     divisor  (sampled at start)
//   start_i       request, held high until ready_o is seen
//   annul_i       flush, aborts any operation in progress
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//
// Build option:
//   DIV_EARLY_EXIT_EN  when defined, a dividend magnitude smaller than the
//                      divisor magnitude skips the iteration loop. The result
//                      value is identical; only the latency changes.

module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q, dvs_d;     // divisor magnitude
  logic [31:0] rem_q, rem_d;     // partial remainder
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag1, mag2;
  logic [32:0] shifted, diff;
  logic        qbit;
  logic [31:0] rem_step, quo_step, rem_fix, quo_fix;
  logic        early_hit;

  // Negation of 0x8000_0000 wraps to itself, which is the correct unsigned
  // magnitude for the most negative operand.
  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value is below twice the divisor and a non-negative
  // difference always fits in 32 bits.
  assign shifted  = {rem_q, dvd_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign qbit     = ~diff[32];
  assign rem_step = qbit ? diff[31:0] : shifted[31:0];
  assign quo_step = {dvd_q[30:0], qbit};
  assign quo_fix  = negq_q ? (~quo_step + 32'd1) : quo_step;
  assign rem_fix  = negr_q ? (~rem_step + 32'd1) : rem_step;

`ifdef DIV_EARLY_EXIT_EN
  assign early_hit = (mag1 < mag2);
`else
  assign early_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      ST_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'h0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'h0) begin
            state_d = ST_BYZERO;
          end else if (early_hit) begin
            // Quotient 0, remainder is the untouched dividend (sign kept).
            result_d = {opdata1_i, 32'h0};
            state_d  = ST_END;
          end else begin
            dvd_d   = mag1;
            dvs_d   = mag2;
            rem_d   = 32'h0;
            negq_d  = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            negr_d  = signed_div_i && opdata1_i[31];
            cnt_d   = 6'd0;
            state_d = ST_ON;
          end
        end
      end

      ST_BYZERO: begin
        if (annul_i || !start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end else begin
          result_d = 64'h0;
          state_d  = ST_END;
        end
      end

      ST_ON: begin
        // A dropped start_i mid-operation is handled exactly like a flush.
        if (annul_i || !start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end else begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
            state_d  = ST_END;
          end
        end
      end

      ST_END: begin
        if (annul_i || !start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end else begin
          // Paths that enter here without a raised flag (divide by zero,
          // early exit) raise it on their first cycle in this state.
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d  = ST_FREE;
        ready_d  = 1'b0;
        result_d = 64'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FREE;
      cnt_q    <= 6'd0;
      dvd_q    <= 32'h0;
      dvs_q    <= 32'h0;
      rem_q    <= 32'h0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= 64'h0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- self-checking bench for div_unit.
// Each started divide pushes its expected result and latency to a
// scoreboard; a monitor pops and compares on every rising ready_o.

module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic ready_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model built on 64-bit arithmetic so the signed overflow case
  // (-2^31 / -1) is computed without trapping and wraps on truncation.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      longint sa, sd;
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      q  = sa / sd;
      r  = sa % sd;
    end else begin
      longint ua, ud;
      ua = longint'({32'h0, a});
      ud = longint'({32'h0, b});
      q  = ua / ud;
      r  = ua % ud;
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (b == 32'h0) return 2;
    ma = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) return 1;
`endif
    return 32;
  endfunction

  // Monitor: every rising ready_o must match the oldest pending request.
  always @(negedge clk) begin
    if (!rst) begin
      ready_prev = 1'b0;
    end else begin
      if (ready_o && !ready_prev) begin
        if (sb.size() == 0) begin
          check_eq("spurious_ready", 64'(ready_o), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn res=%h exp=%h latency=%0d exp_latency=%0d", result_o, e.res, cyc - e.e0, e.lat);
          check_eq("result", result_o, e.res);
          check_eq("latency", 64'(cyc - e.e0), 64'(e.lat));
        end
      end
      ready_prev = ready_o;
    end
  end

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit track);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (track) sb.push_back('{model(sgn, a, b), lat_model(sgn, a, b), cyc + 1});
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_o && n < 100);
    ok = ready_o;
    if (!ok) begin
      check_eq("ready_timeout", 64'd0, 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  // Full handshake: start, wait for ready, confirm hold, drop start, confirm clear.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    logic [63:0] exp;
    exp = model(sgn, a, b);
    start_op(sgn, a, b, 1'b1);
    wait_ready(ok);
    if (ok) begin
      @(negedge clk);
      check_eq("hold_ready", 64'(ready_o), 64'd1);
      check_eq("hold_result", result_o, exp);
      start_i = 1'b0;
      @(negedge clk);
      check_eq("drop_ready", 64'(ready_o), 64'd0);
      check_eq("drop_result", result_o, 64'h0);
    end else begin
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h0;
    opdata2_i    = 32'h0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_ready", 64'(ready_o), 64'd0);
    check_eq("reset_result", result_o, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    do_div(1'b0, 32'd7, 32'd2);                  // 0000_0001_0000_0003
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2);          // FFFF_FFFF_FFFF_FFFD
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  // 0000_0000_8000_0000
    do_div(1'b0, 32'h1234_5678, 32'h0);          // divide by zero
    do_div(1'b1, 32'hFFFF_FFFF, 32'h0);

    // Annul at cnt=10 with start still high: annul must win.
    start_op(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("annul_no_ready", 64'(ready_o), 64'd0);
      check_eq("annul_no_result", result_o, 64'h0);
    end
    do_div(1'b0, 32'd100, 32'd7);                // 0000_0002_0000_000E

    // Early-exit candidates (full latency unless the option is built in).
    do_div(1'b0, 32'd5, 32'd9);                  // 0000_0005_0000_0000
    do_div(1'b1, 32'hFFFF_FFFB, 32'd9);          // FFFF_FFFB_0000_0000

    // Start dropped mid-iteration behaves as a flush.
    start_op(1'b0, 32'd50, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("drop_on_no_ready", 64'(ready_o), 64'd0);
    end

    // Assorted operands, both signednesses.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 3 == 0) ? ($urandom & 32'hFF) + 32'd1 : $urandom;
      do_div(1'(i % 2), a, b);
    end

    // Asynchronous reset while the result is held clears outputs at once.
    start_op(1'b0, 32'd20, 32'd6, 1'b1);
    wait_ready(ok);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_ready", 64'(ready_o), 64'd0);
    check_eq("async_rst_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 64'(ready_o), 64'd0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7);          // -100 / 7

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider serving the DIV/DIVU instructions of the dual-issue pipeline. It sits directly beside the execute stage: it consumes the operands, start request and signedness that issue slot 1 drives, and returns a 64-bit {remainder, quotient} result with a ready flag. The execute stage holds the pipeline stalled until that flag is seen. The core is a radix-2 restoring divider with one quotient bit per cycle, plus sign pre-processing and fix-up.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU; sampled at start.
- opdata1_i  in  32  dividend; sampled at start.
- opdata2_i  in  32  divisor; sampled at start.
- start_i  in  1  request; held high by the execute stage until ready_o is seen.
- annul_i  in  1  flush; aborts any operation in progress.
- result_o  out  64  [63:32] remainder (HI), [31:0] quotient (LO); registered.
- ready_o  out  1  result valid; registered.

## Operation
- States:
  - FREE: idle.
  - BYZERO: divisor is 0.
  - ON: iterating.
  - END: result held.
- Reset: state FREE, cnt 0, result_o 0, ready_o 0.
- FREE:
  - If start_i=1, annul_i=0 and opdata2_i=0: go to BYZERO.
  - If start_i=1, annul_i=0 and opdata2_i≠0: latch the operand magnitudes and the sign flags, clear the partial remainder, set cnt=0, go to ON.
  - Magnitudes are two's-complement negated when signed_div_i=1 and the operand is negative.
  - Sign flags: quotient is negative if the operand signs differ; remainder takes the dividend's sign.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: result_o = 64'h0, go to END next edge.
- ON (each edge):
  - Shift {partial remainder, dividend} left 1.
  - Trial-subtract the divisor magnitude on a 33-bit subtraction.
  - If the result is non-negative, keep the difference and set the quotient bit to 1; else 0.
  - cnt increments.
  - On the edge where cnt goes from 31 to 32: apply sign fix-up (negate quotient and/or remainder per the flags), load result_o, set ready_o=1, go to END.
- END:
  - While start_i=1 and annul_i=0: hold result_o and ready_o.
  - When start_i=0: go to FREE, clear ready_o and result_o.
- annul_i=1 in any state: next edge goes to FREE, ready_o=0, result_o=0. It has priority over start_i in the same cycle.
- start_i falling in ON or BYZERO is treated as annul.
- Overflow case: signed 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0 (wraps, no exception).

## Timing
- Edge E0: FREE samples start_i.
- Normal divide: ready_o is high after edge E0+32, i.e. 33 edges including capture.
- Divide by zero: ready_o is high after E0+2.
- ready_o is held until the first edge that sees start_i=0.
- One operation at a time; a new start_i is accepted only in FREE.
- Back-to-back throughput is one operation per 34 cycles minimum.
- Outputs are registered; there is no combinational path from inputs to outputs.
- An asynchronous reset mid-operation discards all state immediately.

## Configuration
- DIV_EARLY_EXIT_EN
  - Defined: in FREE with a non-zero divisor, if the dividend magnitude is less than the divisor magnitude, skip ON.
    - Quotient is 0 and remainder is the original dividend (sign preserved).
    - Go to END with ready_o high after E0+1.
  - Undefined: every non-zero divisor takes the full 32-iteration path.
  - Results are bit-identical either way.

## Test plan
- Unsigned 7 / 2, start held → ready_o rises after E0+32, result_o = 64'h0000_0001_0000_0003; start_i dropped → next cycle ready_o=0, result_o=0.
- Signed −7 / 2 (0xFFFF_FFF9, 0x2) → result_o = 64'hFFFF_FFFF_FFFF_FFFD.
- Signed 0x8000_0000 / 0xFFFF_FFFF → result_o = 64'h0000_0000_8000_0000.
- Divisor 0 → ready_o after E0+2, result_o = 0; FREE is re-entered after start_i drops.
- Annul at cnt=10, then a new start 5 cycles later with 100 / 7 unsigned → no stale ready_o; result_o = 64'h0000_0002_0000_000E.
- DIV_EARLY_EXIT_EN defined, unsigned 5 / 9 → ready_o after E0+1, result_o = 64'h0000_0005_0000_0000; undefined → same value after E0+32.
